// File: rtl/dm_arbiter.sv
// Data-memory arbiter shared by the two issue pipelines.
// Merges compatible same-cycle accesses and otherwise serialises p1 behind p0 with a one-cycle stall.
module dm_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req_in,
    input  logic          p0_we_in,
    input  logic [AW-1:0] p0_addr_in,
    input  logic [DW-1:0] p0_wdata_in,
    input  logic          p1_req_in,
    input  logic          p1_we_in,
    input  logic [AW-1:0] p1_addr_in,
    input  logic [DW-1:0] p1_wdata_in,
    input  logic          flush_p1_in,
    output logic [AW-1:0] mem_addr_out,
    output logic [DW-1:0] mem_wdata_out,
    output logic          mem_write_out,
    input  logic [DW-1:0] mem_rdata_in,
    output logic [DW-1:0] p0_rdata_out,
    output logic          p0_rvalid_out,
    output logic [DW-1:0] p1_rdata_out,
    output logic          p1_rvalid_out,
    output logic          stall_out
);

    typedef enum logic {IDLE, P1_PEND} state_t;

    state_t        state, next_state;
    logic          pend_we;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_wdata;
    logic          p0_rd_q, p1_rd_q, p1_fwd_q;
    logic [DW-1:0] fwd_data_q, p0_hold_q, p1_hold_q;
    logic          p0_issue_rd, p1_issue_rd, p1_fwd, capture, same_addr;

    assign same_addr = (p0_addr_in == p1_addr_in);

    always_comb begin
        next_state    = state;
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        mem_write_out = 1'b0;
        stall_out     = 1'b0;
        p0_issue_rd   = 1'b0;
        p1_issue_rd   = 1'b0;
        p1_fwd        = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req_in && p1_req_in) begin
                    if (same_addr && !p0_we_in && !p1_we_in) begin
                        mem_addr_out = p0_addr_in;
                        p0_issue_rd  = 1'b1;
                        p1_issue_rd  = 1'b1;
                    end else if (same_addr && p0_we_in && !p1_we_in) begin
                        // p1 reads what p0 is writing, so hand it the write data directly
                        mem_addr_out  = p0_addr_in;
                        mem_wdata_out = p0_wdata_in;
                        mem_write_out = 1'b1;
                        p1_fwd        = 1'b1;
                    end else if (same_addr && p0_we_in && p1_we_in) begin
                        mem_addr_out  = p1_addr_in;
                        mem_wdata_out = p1_wdata_in;
                        mem_write_out = 1'b1;
                    end else begin
                        mem_addr_out  = p0_addr_in;
                        mem_wdata_out = p0_we_in ? p0_wdata_in : '0;
                        mem_write_out = p0_we_in;
                        p0_issue_rd   = !p0_we_in;
                        stall_out     = 1'b1;
                        capture       = 1'b1;
                        next_state    = P1_PEND;
                    end
                end else if (p0_req_in) begin
                    mem_addr_out  = p0_addr_in;
                    mem_wdata_out = p0_we_in ? p0_wdata_in : '0;
                    mem_write_out = p0_we_in;
                    p0_issue_rd   = !p0_we_in;
                end else if (p1_req_in) begin
                    mem_addr_out  = p1_addr_in;
                    mem_wdata_out = p1_we_in ? p1_wdata_in : '0;
                    mem_write_out = p1_we_in;
                    p1_issue_rd   = !p1_we_in;
                end
            end
            P1_PEND: begin
                next_state = IDLE;
                if (!flush_p1_in) begin
                    mem_addr_out  = pend_addr;
                    mem_wdata_out = pend_we ? pend_wdata : '0;
                    mem_write_out = pend_we;
                    p1_issue_rd   = !pend_we;
                end
            end
            default: next_state = IDLE;
        endcase
        // Keep the memory quiet while reset is held, even if the pipelines still request
        if (!rst) begin
            mem_addr_out  = '0;
            mem_wdata_out = '0;
            mem_write_out = 1'b0;
            stall_out     = 1'b0;
            p0_issue_rd   = 1'b0;
            p1_issue_rd   = 1'b0;
            p1_fwd        = 1'b0;
            capture       = 1'b0;
            next_state    = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            p0_rd_q    <= 1'b0;
            p1_rd_q    <= 1'b0;
            p1_fwd_q   <= 1'b0;
            fwd_data_q <= '0;
            p0_hold_q  <= '0;
            p1_hold_q  <= '0;
        end else begin
            state    <= next_state;
            p0_rd_q  <= p0_issue_rd;
            p1_rd_q  <= p1_issue_rd;
            p1_fwd_q <= p1_fwd;
            if (capture) begin
                pend_we    <= p1_we_in;
                pend_addr  <= p1_addr_in;
                pend_wdata <= p1_wdata_in;
            end
            if (p1_fwd)
                fwd_data_q <= p0_wdata_in;
            if (p0_rd_q)
                p0_hold_q <= mem_rdata_in;
            if (p1_fwd_q)
                p1_hold_q <= fwd_data_q;
            else if (p1_rd_q)
                p1_hold_q <= mem_rdata_in;
        end
    end

    // Read data is live during the pulse and held from the registers afterwards
    assign p0_rvalid_out = p0_rd_q;
    assign p1_rvalid_out = p1_rd_q | p1_fwd_q;
    assign p0_rdata_out  = p0_rd_q ? mem_rdata_in : p0_hold_q;
    assign p1_rdata_out  = p1_fwd_q ? fwd_data_q : (p1_rd_q ? mem_rdata_in : p1_hold_q);

endmodule
